// File: rtl/ofifo_psum_collector_pkg.sv
// ---------------------------------------------------------------------------
// ofifo_psum_collector_pkg
//   Shared definitions for the MAC-array south-edge output path: default
//   column count and psum width, the psum word type used by mac_tile and the
//   SFU, and the pointer-width helper for the column FIFOs.
// ---------------------------------------------------------------------------
package ofifo_psum_collector_pkg;

    localparam int COL_DEF     = 8;
    localparam int PSUM_BW_DEF = 16;
    localparam int DEPTH_DEF   = 64;

    // One psum word, two's complement, shared with mac_tile and the SFU.
    typedef logic signed [PSUM_BW_DEF-1:0] psum_t;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ofifo_psum_collector_fifo_column.sv
// ---------------------------------------------------------------------------
// fifo_column
//   Single-column circular FIFO with first-word fall-through head.
//   Ports:
//     clk, reset : clock, synchronous active-high reset (pointers only)
//     wr, din    : write strobe and word; dropped when full
//     rd         : pop head; ignored when empty
//     dout       : head word (zero while empty)
//     full,empty : occupancy flags, combinational from the pointers
// ---------------------------------------------------------------------------
module fifo_column
    import ofifo_psum_collector_pkg::*;
#(
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int depth   = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic [psum_bw-1:0] din,
    input  logic               rd,
    output logic [psum_bw-1:0] dout,
    output logic               full,
    output logic               empty
);

    localparam int PW = ptr_w(depth);
    localparam int AW = PW - 1;

    logic [psum_bw-1:0] mem_q [depth];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic               wr_en_s;

    // Occupancy flags, head word and next pointers.
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                  (wr_ptr_q[AW] != rd_ptr_q[AW]);
        wr_en_s = wr && !full;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd && !empty) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        // Masking the head while empty keeps out at zero after reset
        // without having to clear the storage array.
        if (empty) begin
            dout = {psum_bw{1'b0}};
        end else begin
            dout = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; not reset, pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en_s && !reset) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/ofifo_psum_collector.sv
// ---------------------------------------------------------------------------
// ofifo_psum_collector
//   Output FIFO on the south edge of the MAC array: one independent FIFO
//   per column, rows presented only when every column holds a word.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     wr [col]    : per-column write strobe
//     in          : column c word at in[c*psum_bw +: psum_bw]
//     rd          : pop one full row (ignored unless o_valid)
//     out         : head row, same packing as in (fall-through)
//     o_valid     : every column non-empty
//     o_full      : any column full;  o_ready = ~o_full
//     o_overflow  : sticky, a write hit a full column
//   Configuration macro OFIFO_RELU_EN: negative words on out read as zero;
//   stored data stays raw.
// ---------------------------------------------------------------------------
module ofifo_psum_collector
    import ofifo_psum_collector_pkg::*;
#(
    parameter int col     = COL_DEF,
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int depth   = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col-1:0]         wr,
    input  logic [col*psum_bw-1:0] in,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow
);

    logic [col-1:0]     full_s;
    logic [col-1:0]     empty_s;
    logic [psum_bw-1:0] head_s [col];
    logic               rd_fire_s;
    logic               overflow_q, overflow_d;

    for (genvar c = 0; c < col; c++) begin : g_col
        fifo_column #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_fifo_column (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[c]),
            .din   (in[c*psum_bw +: psum_bw]),
            .rd    (rd_fire_s),
            .dout  (head_s[c]),
            .full  (full_s[c]),
            .empty (empty_s[c])
        );
    end

    // Flag reduction, row pop fan-out and sticky overflow next state.
    always_comb begin
        o_valid    = ~|empty_s;
        o_full     = |full_s;
        o_ready    = ~o_full;
        // Rows pop only as a whole, so rd is gated by o_valid.
        rd_fire_s  = rd && o_valid;
        // Full check uses pre-edge state: a same-cycle pop does not make room.
        overflow_d = overflow_q | (|(wr & full_s));
        o_overflow = overflow_q;
    end

    // Read-side output packing with optional ReLU.
    always_comb begin
        out = {(col*psum_bw){1'b0}};
        for (int c = 0; c < col; c++) begin
`ifdef OFIFO_RELU_EN
            if (head_s[c][psum_bw-1]) begin
                out[c*psum_bw +: psum_bw] = {psum_bw{1'b0}};
            end else begin
                out[c*psum_bw +: psum_bw] = head_s[c];
            end
`else
            out[c*psum_bw +: psum_bw] = head_s[c];
`endif
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_ofifo_psum_collector.sv
module tb_ofifo_psum_collector;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int DEP = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [COL-1:0]    wr = '0;
    logic [COL*BW-1:0] in_v = '0;
    logic              rd = 1'b0;
    logic [COL*BW-1:0] out_v;
    logic              o_valid, o_full, o_ready, o_overflow;

    int errors = 0;
    int checks = 0;

    ofifo_psum_collector #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
        .clk(clk), .reset(reset), .wr(wr), .in(in_v), .rd(rd),
        .out(out_v), .o_valid(o_valid), .o_full(o_full),
        .o_ready(o_ready), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr = '0; rd = 1'b0; in_v = '0;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_full !== 1'b0 || o_ready !== 1'b1 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got v=%b f=%b r=%b ov=%b, want 0 0 1 0", o_valid, o_full, o_ready, o_overflow);
        end
        checks++;
        if (out_v !== '0) begin
            errors++;
            $display("FAIL reset_out: got %h, want 0", out_v);
        end
    endtask

    task automatic test_skew();
        logic [COL*BW-1:0] exp;
        test_reset();
        exp = '0;
        for (int c = 0; c < COL; c++) begin
            wr = '0; wr[c] = 1'b1;
            in_v = '0; in_v[c*BW +: BW] = BW'(c + 1);
            exp[c*BW +: BW] = BW'(c + 1);
            checks++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL skew_valid_early col%0d: got %b, want 0", c, o_valid);
            end
            tick();
        end
        wr = '0;
        checks++;
        if (o_valid !== 1'b1 || out_v !== exp) begin
            errors++;
            $display("FAIL skew_row: got v=%b out=%h, want v=1 out=%h", o_valid, out_v, exp);
        end
        rd = 1'b1; tick(); rd = 1'b0;
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL skew_pop: got v=%b, want 0", o_valid);
        end
    endtask

    task automatic test_fill_overflow();
        test_reset();
        for (int i = 0; i < DEP; i++) begin
            wr = 8'b0000_1000; in_v = '0; in_v[3*BW +: BW] = BW'(i);
            if (i == DEP - 1) begin
                checks++;
                if (o_full !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_not_full_yet: got %b, want 0", o_full);
                end
            end
            tick();
        end
        checks++;
        if (o_full !== 1'b1 || o_ready !== 1'b0 || o_valid !== 1'b0 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_flags: got f=%b r=%b v=%b ov=%b, want 1 0 0 0", o_full, o_ready, o_valid, o_overflow);
        end
        in_v[3*BW +: BW] = 16'hAAAA; tick();
        checks++;
        if (o_overflow !== 1'b1 || o_full !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: got ov=%b f=%b, want 1 1", o_overflow, o_full);
        end
        for (int i = 0; i < DEP; i++) begin
            wr = 8'b1111_0111; in_v = '0;
            for (int c = 0; c < COL; c++) in_v[c*BW +: BW] = BW'(i);
            tick();
        end
        wr = '0;
        for (int i = 0; i < DEP; i++) begin
            checks++;
            if (o_valid !== 1'b1 || out_v[3*BW +: BW] !== BW'(i)) begin
                errors++;
                $display("FAIL fill_order row%0d: got v=%b col3=%h, want 1 %h", i, o_valid, out_v[3*BW +: BW], BW'(i));
            end
            rd = 1'b1; tick(); rd = 1'b0;
        end
        checks++;
        if (o_valid !== 1'b0 || o_full !== 1'b0 || o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL fill_drained: got v=%b f=%b ov=%b, want 0 0 1", o_valid, o_full, o_overflow);
        end
    endtask

    task automatic test_rd_empty();
        test_reset();
        wr = 8'b1101_1111; in_v = '0;
        for (int c = 0; c < COL; c++) in_v[c*BW +: BW] = BW'(100 + c);
        tick(); wr = '0;
        rd = 1'b1; tick(); rd = 1'b0;
        for (int c = 0; c < COL; c++) begin
            if (c != 5) begin
                checks++;
                if (out_v[c*BW +: BW] !== BW'(100 + c)) begin
                    errors++;
                    $display("FAIL rd_empty_out col%0d: got %h, want %h", c, out_v[c*BW +: BW], BW'(100 + c));
                end
            end
        end
        checks++;
        if (o_valid !== 1'b0 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL rd_empty_flags: got v=%b ov=%b, want 0 0", o_valid, o_overflow);
        end
        wr = 8'b0010_0000; in_v = '0; in_v[5*BW +: BW] = 16'd55; tick(); wr = '0;
        checks++;
        if (o_valid !== 1'b1 || out_v[0 +: BW] !== 16'd100 || out_v[5*BW +: BW] !== 16'd55) begin
            errors++;
            $display("FAIL rd_empty_ptrs: got v=%b c0=%h c5=%h, want 1 0064 0037", o_valid, out_v[0 +: BW], out_v[5*BW +: BW]);
        end
        rd = 1'b1; tick(); rd = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL rd_empty_pop: got v=%b ov=%b, want 0 0", o_valid, o_overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [COL*BW-1:0] exp;
        test_reset();
        wr = '1; in_v = '0;
        for (int c = 0; c < COL; c++) in_v[c*BW +: BW] = BW'(c * 256);
        tick();
        for (int k = 1; k <= 200; k++) begin
            for (int c = 0; c < COL; c++) begin
                exp[c*BW +: BW] = BW'((k - 1) + c * 256);
                in_v[c*BW +: BW] = BW'(k + c * 256);
            end
            wr = '1; rd = 1'b1;
            checks++;
            if (o_valid !== 1'b1 || out_v !== exp) begin
                errors++;
                $display("FAIL b2b_row%0d: got v=%b out=%h, want 1 %h", k, o_valid, out_v, exp);
            end
            tick();
        end
        wr = '0; rd = 1'b0;
        for (int c = 0; c < COL; c++) exp[c*BW +: BW] = BW'(200 + c * 256);
        checks++;
        if (o_valid !== 1'b1 || out_v !== exp || o_overflow !== 1'b0 || o_full !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got v=%b ov=%b f=%b out=%h, want 1 0 0 %h", o_valid, o_overflow, o_full, out_v, exp);
        end
        rd = 1'b1; tick(); rd = 1'b0;
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got v=%b, want 0", o_valid);
        end
    endtask

    task automatic test_reset_midop();
        test_reset();
        for (int i = 0; i < DEP + 1; i++) begin
            wr = (i < 10) ? 8'hFF : 8'h01;
            for (int c = 0; c < COL; c++) in_v[c*BW +: BW] = BW'(i + c + 1);
            tick();
        end
        wr = '0;
        checks++;
        if (o_valid !== 1'b1 || o_overflow !== 1'b1 || o_full !== 1'b1) begin
            errors++;
            $display("FAIL midop_pre: got v=%b ov=%b f=%b, want 1 1 1", o_valid, o_overflow, o_full);
        end
        reset = 1'b1; wr = '1; rd = 1'b1; tick();
        reset = 1'b0; wr = '0; rd = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_overflow !== 1'b0 || out_v !== '0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL midop_reset: got v=%b ov=%b r=%b out=%h, want 0 0 1 0", o_valid, o_overflow, o_ready, out_v);
        end
        tick();
        checks++;
        if (o_valid !== 1'b0 || out_v !== '0) begin
            errors++;
            $display("FAIL midop_wr_ignored: got v=%b out=%h, want 0 0", o_valid, out_v);
        end
    endtask

    task automatic test_relu();
        logic [BW-1:0] exp_neg;
        test_reset();
`ifdef OFIFO_RELU_EN
        exp_neg = 16'h0000;
`else
        exp_neg = 16'hFFFE;
`endif
        wr = '1;
        for (int c = 0; c < COL; c++) in_v[c*BW +: BW] = (c % 2 == 0) ? 16'hFFFE : 16'h0005;
        tick(); wr = '0;
        checks++;
        if (o_valid !== 1'b1 || out_v[0 +: BW] !== exp_neg || out_v[BW +: BW] !== 16'h0005) begin
            errors++;
            $display("FAIL relu: got v=%b c0=%h c1=%h, want 1 %h 0005", o_valid, out_v[0 +: BW], out_v[BW +: BW], exp_neg);
        end
    endtask

    initial begin
        test_reset();
        test_skew();
        test_fill_overflow();
        test_rd_empty();
        test_back_to_back();
        test_reset_midop();
        test_relu();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
